// File: rtl/snake_vga_render.sv
// snake_vga_render: VGA reader of the snake state bus (one 10x10 cell per grid position).
// A per-line scan FSM builds the next line's row bitmap during horizontal blanking.
module snake_vga_render #(
    parameter int MAX_SIZE = 100,
    parameter int XSIZE    = 48,
    parameter int YSIZE    = 64,
    parameter int CLK_DIV  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [MAX_SIZE*6-1:0] i_Body_x,
    input  logic [MAX_SIZE*6-1:0] i_Body_y,
    input  logic [5:0]            i_Item_x,
    input  logic [5:0]            i_Item_y,
    input  logic [11:0]           i_Size,
    input  logic                  i_Stop,
    output logic                  o_Hsync,
    output logic                  o_Vsync,
    output logic [3:0]            o_Red,
    output logic [3:0]            o_Green,
    output logic [3:0]            o_Blue,
    output logic                  o_Frame_Done
);
    // Visible area follows the grid size; porches and sync widths are fixed.
    localparam int H_VIS = YSIZE * 10;
    localparam int H_SS  = H_VIS + 16;
    localparam int H_SE  = H_SS + 96;
    localparam int H_TOT = H_SE + 48;
    localparam int V_VIS = XSIZE * 10;
    localparam int V_SS  = V_VIS + 10;
    localparam int V_SE  = V_SS + 2;
    localparam int V_TOT = V_SE + 33;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW    = $clog2(MAX_SIZE + 1);
    localparam int YW    = (YSIZE > 1) ? $clog2(YSIZE) : 1;
    localparam int BW    = $clog2(MAX_SIZE * 6);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DONE
    } scan_t;

    logic [DW-1:0]    div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [3:0]       px_sub_q, px_sub_d, ln_sub_q, ln_sub_d;
    logic [6:0]       cell_col_q, cell_col_d;
    logic [5:0]       cell_row_q, cell_row_d;
    logic [5:0]       item_x_q, item_x_d, item_y_q, item_y_d;
    logic [IW-1:0]    size_l_q, size_l_d;
    scan_t            st_q, st_d;
    logic [5:0]       tgt_row_q, tgt_row_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [YSIZE-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [5:0]       head_col_s_q, head_col_s_d, head_col_q, head_col_d;
    logic             head_vld_s_q, head_vld_s_d, head_vld_q, head_vld_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, fdone_q, fdone_d;
    logic [11:0]      rgb_q, rgb_d;

    logic          pix_en, h_end, v_end, line_end, vis, wall;
    logic          is_head, is_item, is_body, ent_ok;
    logic [5:0]    nxt_row, ent_x, ent_y;
    logic [IW-1:0] rd_idx;
    logic [BW-1:0] ent_base;
    logic [11:0]   rgb_c;

    assign pix_en   = (div_q == DW'(CLK_DIV - 1));
    assign h_end    = (h_q == 10'(H_TOT - 1));
    assign v_end    = (v_q == 10'(V_TOT - 1));
    assign line_end = pix_en && h_end;

    always_comb begin
        div_d      = div_q + 1'b1;
        h_d        = h_q;
        v_d        = v_q;
        px_sub_d   = px_sub_q;
        cell_col_d = cell_col_q;
        ln_sub_d   = ln_sub_q;
        cell_row_d = cell_row_q;
        if (pix_en) begin
            div_d = '0;
            if (h_end) begin
                h_d        = '0;
                px_sub_d   = '0;
                cell_col_d = '0;
            end else begin
                h_d = h_q + 10'd1;
                if (px_sub_q == 4'd9) begin
                    px_sub_d   = '0;
                    cell_col_d = cell_col_q + 7'd1;
                end else begin
                    px_sub_d = px_sub_q + 4'd1;
                end
            end
        end
        if (line_end) begin
            if (v_end) begin
                v_d        = '0;
                ln_sub_d   = '0;
                cell_row_d = '0;
            end else begin
                v_d = v_q + 10'd1;
                if (ln_sub_q == 4'd9) begin
                    ln_sub_d   = '0;
                    cell_row_d = cell_row_q + 6'd1;
                end else begin
                    ln_sub_d = ln_sub_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        item_x_d = item_x_q;
        item_y_d = item_y_q;
        size_l_d = size_l_q;
        if (pix_en && h_q == 10'd0 && v_q == 10'd0) begin
            item_x_d = i_Item_x;
            item_y_d = i_Item_y;
            size_l_d = (i_Size > 12'(MAX_SIZE)) ? IW'(MAX_SIZE) : i_Size[IW-1:0];
        end
    end

    always_comb begin
        if (v_end) begin
            nxt_row = '0;
        end else if (ln_sub_q == 4'd9) begin
            nxt_row = cell_row_q + 6'd1;
        end else begin
            nxt_row = cell_row_q;
        end
    end

    // idx reaches size_l on the terminating cycle; keep that read in range.
    assign rd_idx   = (int'(idx_q) < MAX_SIZE) ? idx_q : '0;
    assign ent_base = BW'(rd_idx) * BW'(6);
    assign ent_x    = i_Body_x[ent_base +: 6];
    assign ent_y    = i_Body_y[ent_base +: 6];
    assign ent_ok   = (ent_x == tgt_row_q) && (7'(ent_x) < 7'(XSIZE))
                   && (7'(ent_y) < 7'(YSIZE));

    always_comb begin
        st_d         = st_q;
        tgt_row_d    = tgt_row_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        head_col_s_d = head_col_s_q;
        head_vld_s_d = head_vld_s_q;
        active_d     = active_q;
        head_col_d   = head_col_q;
        head_vld_d   = head_vld_q;
        unique case (st_q)
            S_IDLE: begin
                if (pix_en && h_q == 10'(H_VIS - 1)) begin
                    st_d      = S_CLEAR;
                    tgt_row_d = nxt_row;
                end
            end
            S_CLEAR: begin
                shadow_d     = '0;
                head_col_s_d = '0;
                head_vld_s_d = 1'b0;
                idx_d        = '0;
                st_d         = S_SCAN;
            end
            S_SCAN: begin
                if (idx_q == size_l_q) begin
                    st_d = S_DONE;
                end else begin
                    if (ent_ok) begin
                        shadow_d[ent_y[YW-1:0]] = 1'b1;
                        if (idx_q == '0) begin
                            head_col_s_d = ent_y;
                            head_vld_s_d = 1'b1;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                end
                if (line_end) st_d = S_IDLE;
            end
            S_DONE: begin
                if (line_end) begin
                    active_d   = shadow_q;
                    head_col_d = head_col_s_q;
                    head_vld_d = head_vld_s_q;
                    st_d       = S_IDLE;
                end
            end
        endcase
        if (st_q == S_CLEAR && line_end) st_d = S_IDLE;
    end

    assign vis     = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
    assign wall    = (cell_row_q == 6'd0) || (cell_row_q == 6'(XSIZE - 1))
                  || (cell_col_q == 7'd0) || (cell_col_q == 7'(YSIZE - 1));
    assign is_head = head_vld_q && (cell_col_q == {1'b0, head_col_q});
    assign is_item = (cell_row_q == item_x_q) && (cell_col_q == {1'b0, item_y_q});
    assign is_body = active_q[cell_col_q[YW-1:0]];

    always_comb begin
        rgb_c = 12'h000;
        if (!vis) begin
            rgb_c = 12'h000;
        end else if (wall) begin
            rgb_c = 12'h888;
        end else if (is_head) begin
            rgb_c = i_Stop ? 12'hF00 : 12'h0F0;
        end else if (is_item) begin
            rgb_c = 12'hF00;
        end else if (is_body) begin
            rgb_c = i_Stop ? 12'h800 : 12'h080;
        end
    end

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (pix_en) begin
            hsync_d = !(h_q >= 10'(H_SS) && h_q < 10'(H_SE));
            vsync_d = !(v_q >= 10'(V_SS) && v_q < 10'(V_SE));
            rgb_d   = rgb_c;
        end
        fdone_d = pix_en && (h_q == 10'd0) && (v_q == 10'(V_VIS));
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            px_sub_q     <= '0;
            cell_col_q   <= '0;
            ln_sub_q     <= '0;
            cell_row_q   <= '0;
            item_x_q     <= '0;
            item_y_q     <= '0;
            size_l_q     <= '0;
            st_q         <= S_IDLE;
            tgt_row_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            head_col_s_q <= '0;
            head_vld_s_q <= 1'b0;
            head_col_q   <= '0;
            head_vld_q   <= 1'b0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            fdone_q      <= 1'b0;
            rgb_q        <= '0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            px_sub_q     <= px_sub_d;
            cell_col_q   <= cell_col_d;
            ln_sub_q     <= ln_sub_d;
            cell_row_q   <= cell_row_d;
            item_x_q     <= item_x_d;
            item_y_q     <= item_y_d;
            size_l_q     <= size_l_d;
            st_q         <= st_d;
            tgt_row_q    <= tgt_row_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            head_col_s_q <= head_col_s_d;
            head_vld_s_q <= head_vld_s_d;
            head_col_q   <= head_col_d;
            head_vld_q   <= head_vld_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            fdone_q      <= fdone_d;
            rgb_q        <= rgb_d;
        end
    end

    assign o_Hsync      = hsync_q;
    assign o_Vsync      = vsync_q;
    assign o_Red        = rgb_q[11:8];
    assign o_Green      = rgb_q[7:4];
    assign o_Blue       = rgb_q[3:0];
    assign o_Frame_Done = fdone_q;
endmodule
